// File: rtl/fml16_sram_ctrl_if.sv
// Bus bundle between the 16-bit FML master, the SRAM controller and the external async SRAM.
// Modports: master = FML upstream, slave = controller, mem = SRAM device.
interface fml16_sram_ctrl_if #(
  parameter int unsigned ADR_W = 24
);
  logic [ADR_W-1:0] fml_adr;
  logic             fml_stb;
  logic             fml_we;
  logic [3:0]       fml_sel;
  logic [31:0]      fml_di;
  logic             fml_ack;
  logic [31:0]      fml_do;
  logic [ADR_W-2:0] sram_adr;
  logic [15:0]      sram_d_o;
  logic             sram_d_oe;
  logic [15:0]      sram_d_i;
  logic             sram_ce_n;
  logic             sram_oe_n;
  logic             sram_we_n;
  logic             sram_bhe_n;
  logic             sram_ble_n;

  modport master (
    output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
    input  fml_ack, fml_do
  );

  modport slave (
    input  fml_adr, fml_stb, fml_we, fml_sel, fml_di, sram_d_i,
    output fml_ack, fml_do, sram_adr, sram_d_o, sram_d_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_bhe_n, sram_ble_n
  );

  modport mem (
    input  sram_adr, sram_d_o, sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_bhe_n, sram_ble_n,
    output sram_d_i
  );
endinterface

// File: rtl/fml16_sram_ctrl.sv
// FML slave driving an asynchronous 16-bit SRAM: one request = one SRAM cycle with wait states,
// write hold and read->write turnaround. Optional single-entry write posting: FML16_SRAM_WPOST_EN.
module fml16_sram_ctrl #(
  parameter int unsigned ADR_W   = 24,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2,
  parameter int unsigned TURN    = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  fml16_sram_ctrl_if.slave bus
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ?
                                     ((RD_WAIT > TURN) ? RD_WAIT : TURN) :
                                     ((WR_WAIT > TURN) ? WR_WAIT : TURN);
  localparam int unsigned CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned RD_LD_I  = RD_WAIT - 1;
  localparam int unsigned WR_LD_I  = WR_WAIT - 1;
  localparam int unsigned TURN_LD_I = (TURN > 0) ? TURN - 1 : 0;
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_LD_I);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WR_LD_I);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_LD_I);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TURN  = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_WHOLD = 3'd4,
    S_ACK   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_rd_q, last_rd_d;
  logic             accept_c;

  logic [ADR_W-2:0] adr_q, adr_d;
  logic [1:0]       sel_q, sel_d;
  logic [15:0]      dat_q, dat_d;

  logic             ce_n_q, ce_n_d;
  logic             oe_n_q, oe_n_d;
  logic             we_n_q, we_n_d;
  logic             bhe_n_q, bhe_n_d;
  logic             ble_n_q, ble_n_d;
  logic             d_oe_q, d_oe_d;
  logic             ack_q, ack_d;
  logic [31:0]      do_q, do_d;

  logic             unused_c;
  assign unused_c = ^{bus.fml_adr[0], bus.fml_sel[3:2], bus.fml_di[31:16]};

  // State register and all SRAM/FML-side output registers; reset releases strobes mid-cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      bhe_n_q   <= 1'b1;
      ble_n_q   <= 1'b1;
      d_oe_q    <= 1'b0;
      ack_q     <= 1'b0;
      do_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      bhe_n_q   <= bhe_n_d;
      ble_n_q   <= ble_n_d;
      d_oe_q    <= d_oe_d;
      ack_q     <= ack_d;
      do_q      <= do_d;
    end
  end

  // Next-state: wait counters load on state entry and count down to zero without wrapping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    accept_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.fml_stb) begin
          accept_c = 1'b1;
          if (bus.fml_we && last_rd_q && (TURN > 0)) begin
            state_d = S_TURN;
            cnt_d   = TURN_LD;
          end else if (bus.fml_we) begin
            state_d = S_WRITE;
            cnt_d   = WR_LD;
          end else begin
            state_d = S_READ;
            cnt_d   = RD_LD;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_WRITE;
          cnt_d   = WR_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ: begin
        if (cnt_q == '0) begin
          state_d   = S_ACK;
          last_rd_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (cnt_q == '0) begin
          state_d = S_WHOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WHOLD: begin
        last_rd_d = 1'b0;
`ifdef FML16_SRAM_WPOST_EN
        // Posted writes were already acked at accept; return straight to IDLE.
        state_d = S_IDLE;
`else
        state_d = S_ACK;
`endif
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture: held stable from accept until the next IDLE.
  always_comb begin
    adr_d = adr_q;
    sel_d = sel_q;
    dat_d = dat_q;
    if (accept_c) begin
      adr_d = bus.fml_adr[ADR_W-1:1];
      sel_d = bus.fml_sel[1:0];
      dat_d = bus.fml_di[15:0];
    end
  end

  // Outputs are decoded from the upcoming state so the pins line up with the state they belong to.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    bhe_n_d = 1'b1;
    ble_n_d = 1'b1;
    d_oe_d  = 1'b0;
    ack_d   = 1'b0;
    do_d    = do_q;
    unique case (state_d)
      S_READ: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        bhe_n_d = 1'b0;
        ble_n_d = 1'b0;
      end
      S_WRITE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        d_oe_d  = 1'b1;
        bhe_n_d = ~sel_d[1];
        ble_n_d = ~sel_d[0];
      end
      S_WHOLD: begin
        ce_n_d  = 1'b0;
        d_oe_d  = 1'b1;
        bhe_n_d = ~sel_d[1];
        ble_n_d = ~sel_d[0];
      end
      S_ACK:   ack_d = 1'b1;
      default: ;
    endcase
    if ((state_q == S_READ) && (cnt_q == '0)) begin
      do_d = {16'h0000, bus.sram_d_i};
    end
`ifdef FML16_SRAM_WPOST_EN
    if (accept_c && bus.fml_we) begin
      ack_d = 1'b1;
    end
`endif
  end

  assign bus.fml_ack    = ack_q;
  assign bus.fml_do     = do_q;
  assign bus.sram_adr   = adr_q;
  assign bus.sram_d_o   = dat_q;
  assign bus.sram_d_oe  = d_oe_q;
  assign bus.sram_ce_n  = ce_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_bhe_n = bhe_n_q;
  assign bus.sram_ble_n = ble_n_q;

endmodule

// File: tb/tb_fml16_sram_ctrl.sv
// Directed bench for fml16_sram_ctrl with an SRAM model and an ack/read-data scoreboard.
// Covers FML16_SRAM_WPOST_EN when that macro is defined for the build.
module tb_fml16_sram_ctrl;

  localparam int unsigned ADR_W   = 24;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned WR_WAIT = 2;
  localparam int unsigned TURN    = 1;
`ifdef FML16_SRAM_WPOST_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fml16_sram_ctrl_if #(.ADR_W(ADR_W)) bus ();

  fml16_sram_ctrl #(
    .ADR_W(ADR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  // SRAM model: byte-lane writes while ce_n/we_n are low, combinational read under oe_n.
  logic [15:0] mem [256];
  logic        init_done = 1'b0;
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h08] <= 16'hBEEF;
      mem[8'h18] <= 16'hA5A5;
      init_done  <= 1'b1;
    end else if (rst_n && !bus.sram_ce_n && !bus.sram_we_n) begin
      if (!bus.sram_ble_n) mem[bus.sram_adr[7:0]][7:0]  <= bus.sram_d_o[7:0];
      if (!bus.sram_bhe_n) mem[bus.sram_adr[7:0]][15:8] <= bus.sram_d_o[15:8];
    end
  end
  assign bus.sram_d_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_adr[7:0]] : 16'h0000;

  typedef struct {
    logic        chk_do;
    logic [31:0] exp_do;
    int          exp_lat;
  } exp_t;
  exp_t sb[$];

  int   total = 0;
  int   bad   = 0;
  logic last_rd_m = 1'b0;
  int   pend_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request starting in an IDLE cycle; returns one cycle after its ack.
  task automatic run_req(input string tag, input logic we, input logic [23:0] adr,
                         input logic [3:0] sel, input logic [31:0] di,
                         input logic keep, input logic [15:0] exp_word);
    exp_t        e, got;
    int          n, oe_low, we_low, first_we, turn_idle, turn_exp;
    logic        done, bhe_s, ble_s, doe_s;
    logic [22:0] adr_s;
    e.chk_do  = !we;
    e.exp_do  = {16'h0000, exp_word};
    turn_exp  = (we && last_rd_m) ? int'(TURN) : 0;
    if (we) e.exp_lat = POST ? 1 : int'(WR_WAIT) + 2 + turn_exp;
    else    e.exp_lat = int'(RD_WAIT) + 1;
    e.exp_lat += pend_stall;
    pend_stall = (POST && we) ? turn_exp + int'(WR_WAIT) : 0;
    last_rd_m  = !we;
    sb.push_back(e);

    bus.fml_stb = 1'b1;
    bus.fml_we  = we;
    bus.fml_adr = adr;
    bus.fml_sel = sel;
    bus.fml_di  = di;
    n = 0; oe_low = 0; we_low = 0; first_we = 0; turn_idle = 0;
    done = 1'b0; bhe_s = 1'b1; ble_s = 1'b1; doe_s = 1'b1; adr_s = '0;
    while (!done && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!bus.sram_oe_n) begin
        oe_low++;
        adr_s = bus.sram_adr;
      end
      if (!bus.sram_we_n) begin
        we_low++;
        if (first_we == 0) first_we = n;
        bhe_s = bus.sram_bhe_n;
        ble_s = bus.sram_ble_n;
        doe_s = doe_s & bus.sram_d_oe;
        adr_s = bus.sram_adr;
      end
      if (first_we == 0 && bus.sram_ce_n && !bus.sram_d_oe) turn_idle++;
      if (bus.fml_ack) done = 1'b1;
    end
    chk({tag, "_ack_seen"}, 32'(done), 32'd1);
    got = sb.pop_front();
    if (done) begin
      chk({tag, "_latency"}, 32'(n), 32'(got.exp_lat));
      if (got.chk_do) chk({tag, "_rdata"}, bus.fml_do, got.exp_do);
      if (!we) begin
        chk({tag, "_oe_cycles"}, 32'(oe_low), 32'(RD_WAIT));
        chk({tag, "_adr"}, 32'(adr_s), 32'(adr[23:1]));
      end else if (!POST) begin
        chk({tag, "_we_cycles"}, 32'(we_low), 32'(WR_WAIT));
        chk({tag, "_turn_cycles"}, 32'(turn_idle), 32'(turn_exp));
        chk({tag, "_lanes"}, {30'h0, bhe_s, ble_s}, {30'h0, ~sel[1], ~sel[0]});
        chk({tag, "_d_oe"}, 32'(doe_s), 32'd1);
        chk({tag, "_adr"}, 32'(adr_s), 32'(adr[23:1]));
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_ack_single"}, 32'(bus.fml_ack), 32'd0);
    if (!keep) bus.fml_stb = 1'b0;
  endtask

  initial begin
    int wait_n;
    bus.fml_stb = 1'b0;
    bus.fml_we  = 1'b0;
    bus.fml_adr = '0;
    bus.fml_sel = 4'h0;
    bus.fml_di  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {27'h0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n,
                        bus.sram_bhe_n, bus.sram_ble_n}, 32'h1F);
    chk("rst_d_oe", 32'(bus.sram_d_oe), 32'd0);
    chk("rst_ack", 32'(bus.fml_ack), 32'd0);
    chk("rst_do", bus.fml_do, 32'h0);
    chk("rst_adr", 32'(bus.sram_adr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_req("wr_lo",     1'b1, 24'h000020, 4'b0001, 32'h00001234, 1'b0, 16'h0000);
    run_req("rd_beef",   1'b0, 24'h000010, 4'b1111, 32'h0,        1'b0, 16'hBEEF);
    run_req("rd_held",   1'b0, 24'h000030, 4'b1111, 32'h0,        1'b1, 16'hA5A5);
    run_req("wr_held",   1'b1, 24'h000030, 4'b0011, 32'h00005A5A, 1'b0, 16'h0000);
    run_req("rd_5a",     1'b0, 24'h000030, 4'b1111, 32'h0,        1'b0, 16'h5A5A);
    run_req("wr_hi",     1'b1, 24'h000010, 4'b0010, 32'hFFFF7700, 1'b0, 16'h0000);
    run_req("rd_77ef",   1'b0, 24'h000010, 4'b1111, 32'h0,        1'b0, 16'h77EF);
    run_req("wr_nosel",  1'b1, 24'h000030, 4'b0000, 32'h0000FFFF, 1'b0, 16'h0000);
    run_req("rd_keep",   1'b0, 24'h000030, 4'b1111, 32'h0,        1'b0, 16'h5A5A);

    // Reset in the middle of a write (preceded by a read, so it starts with turnaround).
    bus.fml_stb = 1'b1;
    bus.fml_we  = 1'b1;
    bus.fml_adr = 24'h000040;
    bus.fml_sel = 4'b0011;
    bus.fml_di  = 32'h0000DEAD;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (bus.sram_we_n && wait_n < 50);
    chk("midrst_we_seen", 32'(bus.sram_we_n), 32'd0);
    #2;
    rst_n = 1'b0;
    bus.fml_stb = 1'b0;
    #1;
    chk("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("midrst_ce_n", 32'(bus.sram_ce_n), 32'd1);
    chk("midrst_d_oe", 32'(bus.sram_d_oe), 32'd0);
    chk("midrst_ack", 32'(bus.fml_ack), 32'd0);
    last_rd_m  = 1'b0;
    pend_stall = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_ack", 32'(bus.fml_ack), 32'd0);
    run_req("rd_after_rst", 1'b0, 24'h000020, 4'b1111, 32'h0, 1'b0, 16'h0034);
    run_req("wr_c0de",      1'b1, 24'h000050, 4'b0011, 32'h0000C0DE, 1'b0, 16'h0000);
    run_req("rd_c0de",      1'b0, 24'h000050, 4'b1111, 32'h0, 1'b0, 16'hC0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
